// File: rtl/neighbor_table_cam.sv
// ID-addressed neighbor table: parallel ID lookup, lowest-free allocation, heartbeat clear, best-Q scan.
// Build option NT_REPLACE_EN: a full-table miss evicts the minimum-energy entry instead of dropping.
module neighbor_table_cam #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned DEPTH = 32,
  parameter logic [WORD_WIDTH-1:0] MY_NODE_ID = WORD_WIDTH'(16'h000C),
  localparam int unsigned IDXW = $clog2(DEPTH),
  localparam int unsigned CNTW = IDXW + 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  wr_en,
  input  logic [WORD_WIDTH-1:0] wr_id,
  input  logic [WORD_WIDTH-1:0] wr_hops,
  input  logic [WORD_WIDTH-1:0] wr_qvalue,
  input  logic [WORD_WIDTH-1:0] wr_energy,
  input  logic [WORD_WIDTH-1:0] wr_ch,
  input  logic [WORD_WIDTH-1:0] wr_chhops,
  input  logic                  hb_reset,
  input  logic                  search_start,
  input  logic [IDXW-1:0]       rd_idx,
  output logic [WORD_WIDTH-1:0] rd_id,
  output logic [WORD_WIDTH-1:0] rd_hops,
  output logic [WORD_WIDTH-1:0] rd_qvalue,
  output logic [WORD_WIDTH-1:0] rd_energy,
  output logic [WORD_WIDTH-1:0] rd_ch,
  output logic [WORD_WIDTH-1:0] rd_chhops,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  wr_done,
  output logic                  wr_hit,
  output logic                  wr_drop,
  output logic                  wr_evict,
  output logic [CNTW-1:0]       count,
  output logic                  full,
  output logic                  search_done,
  output logic [IDXW-1:0]       best_idx,
  output logic                  best_valid
);

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITE, CLEAR, SEARCH} state_t;
  typedef struct packed {
    logic [WORD_WIDTH-1:0] id, hops, qvalue, energy, ch, chhops;
  } rec_t;

  localparam logic [IDXW-1:0] LAST_IDX     = IDXW'(DEPTH - 1);
  localparam logic [IDXW-1:0] PRE_LAST_IDX = IDXW'(DEPTH - 2);
  localparam logic [CNTW-1:0] FULL_M1      = CNTW'(DEPTH - 1);

  state_t                state, state_nxt;
  rec_t                  tbl [DEPTH];
  logic [DEPTH-1:0]      valid;
  rec_t                  rec_q;
  logic                  hb_pend;
  logic [IDXW-1:0]       scan_idx, scan_ent, run_idx, lk_idx;
  logic                  run_found, lk_drop, lk_alloc, take;
  logic [WORD_WIDTH-1:0] run_q;
  logic                  hit, free_found;
  logic [IDXW-1:0]       hit_idx, free_idx, tgt_idx;
  logic                  tgt_drop, tgt_hit, tgt_alloc;
`ifdef NT_REPLACE_EN
  logic                  tgt_evict;
  logic [IDXW-1:0]       min_idx;
  logic [WORD_WIDTH-1:0] min_e;
`endif

  assign rd_id     = tbl[rd_idx].id;
  assign rd_hops   = tbl[rd_idx].hops;
  assign rd_qvalue = tbl[rd_idx].qvalue;
  assign rd_energy = tbl[rd_idx].energy;
  assign rd_ch     = tbl[rd_idx].ch;
  assign rd_chhops = tbl[rd_idx].chhops;
  assign rd_valid  = valid[rd_idx];

  // Parallel compare of the latched ID; descending loops leave the lowest matching index
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid[i] && tbl[i].id == rec_q.id) begin
        hit     = 1'b1;
        hit_idx = IDXW'(i);
      end
      if (!valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDXW'(i);
      end
    end
`ifdef NT_REPLACE_EN
    min_e   = tbl[0].energy;
    min_idx = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (tbl[i].energy < min_e) begin
        min_e   = tbl[i].energy;
        min_idx = IDXW'(i);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (hb_reset || hb_pend) state_nxt = CLEAR;
        else if (wr_en)          state_nxt = LOOKUP;
        else if (search_start)   state_nxt = SEARCH;
      end
      LOOKUP:      state_nxt = WRITE;
      WRITE, CLEAR: state_nxt = IDLE;
      SEARCH:      if (scan_idx == LAST_IDX) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  // Write target decision and scan comparison
  always_comb begin
    tgt_drop  = 1'b0;
    tgt_hit   = 1'b0;
    tgt_alloc = 1'b0;
    tgt_idx   = '0;
`ifdef NT_REPLACE_EN
    tgt_evict = 1'b0;
`endif
    if (rec_q.id == MY_NODE_ID) begin
      tgt_drop = 1'b1;
    end else if (hit) begin
      tgt_hit = 1'b1;
      tgt_idx = hit_idx;
    end else if (free_found) begin
      tgt_alloc = 1'b1;
      tgt_idx   = free_idx;
    end else begin
`ifdef NT_REPLACE_EN
      tgt_evict = 1'b1;
      tgt_idx   = min_idx;
`else
      tgt_drop  = 1'b1;
`endif
    end
    // Entry 0 is folded in at scan start, so SEARCH cycle k examines entry k+1
    scan_ent = scan_idx + IDXW'(1);
    take     = valid[scan_ent] && (!run_found || tbl[scan_ent].qvalue > run_q);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
      valid       <= '0;
      rec_q       <= '0;
      hb_pend     <= 1'b0;
      scan_idx    <= '0;
      run_idx     <= '0;
      run_found   <= 1'b0;
      run_q       <= '0;
      lk_idx      <= '0;
      lk_drop     <= 1'b0;
      lk_alloc    <= 1'b0;
      busy        <= 1'b0;
      wr_done     <= 1'b0;
      wr_hit      <= 1'b0;
      wr_drop     <= 1'b0;
      count       <= '0;
      full        <= 1'b0;
      search_done <= 1'b0;
      best_idx    <= '0;
      best_valid  <= 1'b0;
    end else begin
      busy        <= (state_nxt != IDLE);
      wr_done     <= (state == LOOKUP);
      wr_hit      <= (state == LOOKUP) && tgt_hit;
      wr_drop     <= (state == LOOKUP) && tgt_drop;
      search_done <= 1'b0;
      if (state == IDLE)  hb_pend <= 1'b0;
      else if (hb_reset)  hb_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (state_nxt == LOOKUP)
            rec_q <= {wr_id, wr_hops, wr_qvalue, wr_energy, wr_ch, wr_chhops};
          if (state_nxt == SEARCH) begin
            scan_idx  <= '0;
            run_found <= valid[0];
            run_idx   <= '0;
            run_q     <= tbl[0].qvalue;
          end
        end
        LOOKUP: begin
          lk_idx   <= tgt_idx;
          lk_drop  <= tgt_drop;
          lk_alloc <= tgt_alloc;
        end
        WRITE: begin
          if (!lk_drop) begin
            tbl[lk_idx]   <= rec_q;
            valid[lk_idx] <= 1'b1;
            if (lk_alloc) begin
              count <= count + CNTW'(1);
              full  <= (count == FULL_M1);
            end
          end
        end
        CLEAR: begin
          valid      <= '0;
          count      <= '0;
          full       <= 1'b0;
          best_valid <= 1'b0;
        end
        SEARCH: begin
          scan_idx <= scan_idx + IDXW'(1);
          if (scan_idx != LAST_IDX && take) begin
            run_found <= 1'b1;
            run_idx   <= scan_ent;
            run_q     <= tbl[scan_ent].qvalue;
          end
          if (scan_idx == PRE_LAST_IDX) begin
            search_done <= 1'b1;
            best_idx    <= take ? scan_ent : run_idx;
            best_valid  <= take || run_found;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef NT_REPLACE_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) wr_evict <= 1'b0;
    else       wr_evict <= (state == LOOKUP) && tgt_evict;
  end
`else
  assign wr_evict = 1'b0;
`endif

endmodule

// File: tb/tb_neighbor_table_cam.sv
// Scoreboard bench for neighbor_table_cam: array-based reference model, randomized traffic, directed corners.
module tb_neighbor_table_cam;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned IDXW  = $clog2(DEPTH);
  localparam logic [15:0] MY_ID = 16'h000C;

  logic clk = 1'b0, nrst = 1'b0;
  logic wr_en = 1'b0, hb_reset = 1'b0, search_start = 1'b0;
  logic [15:0] wr_id = '0, wr_hops = '0, wr_qvalue = '0, wr_energy = '0, wr_ch = '0, wr_chhops = '0;
  logic [IDXW-1:0] rd_idx = '0;
  logic [15:0] rd_id, rd_hops, rd_qvalue, rd_energy, rd_ch, rd_chhops;
  logic rd_valid, busy, wr_done, wr_hit, wr_drop, wr_evict, full, search_done, best_valid;
  logic [IDXW:0] count;
  logic [IDXW-1:0] best_idx;

  neighbor_table_cam #(.WORD_WIDTH(16), .DEPTH(DEPTH), .MY_NODE_ID(MY_ID)) dut (
    .clk(clk), .nrst(nrst), .wr_en(wr_en), .wr_id(wr_id), .wr_hops(wr_hops),
    .wr_qvalue(wr_qvalue), .wr_energy(wr_energy), .wr_ch(wr_ch), .wr_chhops(wr_chhops),
    .hb_reset(hb_reset), .search_start(search_start), .rd_idx(rd_idx),
    .rd_id(rd_id), .rd_hops(rd_hops), .rd_qvalue(rd_qvalue), .rd_energy(rd_energy),
    .rd_ch(rd_ch), .rd_chhops(rd_chhops), .rd_valid(rd_valid), .busy(busy),
    .wr_done(wr_done), .wr_hit(wr_hit), .wr_drop(wr_drop), .wr_evict(wr_evict),
    .count(count), .full(full), .search_done(search_done), .best_idx(best_idx),
    .best_valid(best_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_search;
    bit hit, drop, evict;
    int cyc;
    int cnt;
    int bidx;
    bit bvalid;
  } exp_t;
  exp_t exq[$];

  // Reference model: record packed as {id, hops, qvalue, energy, ch, chhops}
  logic [95:0] m_data [DEPTH];
  bit          m_valid [DEPTH];

  int n_total = 0, n_pass = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_valid[i]);
    return n;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_data[i]  = '0;
      m_valid[i] = 1'b0;
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
  endfunction

  task automatic idle_wait();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", 128'(busy), 128'(0));
  endtask

  // Applies the table rules to the model, queues the expected response, then drives the request
  task automatic issue_write(input logic [15:0] id, hops, q, e, ch, chh);
    exp_t x;
    int idx = -1;
    x.is_search = 1'b0; x.hit = 1'b0; x.drop = 1'b0; x.evict = 1'b0;
    x.bidx = 0; x.bvalid = 1'b0;
    if (id == MY_ID) x.drop = 1'b1;
    else begin
      for (int i = 0; i < DEPTH; i++)
        if (m_valid[i] && m_data[i][95:80] == id) idx = i;
      if (idx >= 0) x.hit = 1'b1;
      else begin
        for (int i = DEPTH - 1; i >= 0; i--)
          if (!m_valid[i]) idx = i;
        if (idx < 0) begin
`ifdef NT_REPLACE_EN
          idx = 0;
          for (int i = 1; i < DEPTH; i++)
            if (m_data[i][47:32] < m_data[idx][47:32]) idx = i;
          x.evict = 1'b1;
`else
          x.drop = 1'b1;
`endif
        end
      end
      if (idx >= 0) begin
        m_data[idx]  = {id, hops, q, e, ch, chh};
        m_valid[idx] = 1'b1;
      end
    end
    x.cnt = model_count();
    x.cyc = cyc + 2;
    exq.push_back(x);
    wr_id = id; wr_hops = hops; wr_qvalue = q; wr_energy = e; wr_ch = ch; wr_chhops = chh;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] id, hops, q, e, ch, chh);
    issue_write(id, hops, q, e, ch, chh);
    idle_wait();
  endtask

  task automatic do_search();
    exp_t x;
    x.is_search = 1'b1; x.hit = 1'b0; x.drop = 1'b0; x.evict = 1'b0; x.cnt = 0;
    x.bidx = 0; x.bvalid = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (m_valid[i] && (!x.bvalid || m_data[i][63:48] > m_data[x.bidx][63:48])) begin
        x.bidx   = i;
        x.bvalid = 1'b1;
      end
    x.cyc = cyc + DEPTH;
    exq.push_back(x);
    search_start = 1'b1;
    @(negedge clk);
    search_start = 1'b0;
    idle_wait();
  endtask

  task automatic do_clear();
    hb_reset = 1'b1;
    @(negedge clk);
    hb_reset = 1'b0;
    model_clear();
    idle_wait();
    chk("clear_count", 128'(count), 128'(0));
    chk("clear_best_valid", 128'(best_valid), 128'(0));
  endtask

  task automatic check_table(input string name);
    for (int i = 0; i < DEPTH; i++) begin
      rd_idx = IDXW'(i);
      #1;
      chk(name, 128'({rd_valid, rd_id, rd_hops, rd_qvalue, rd_energy, rd_ch, rd_chhops}),
          128'({m_valid[i], m_data[i]}));
    end
    @(negedge clk);
  endtask

  function automatic logic [15:0] rand_id();
    if ($urandom_range(0, 11) == 0) return MY_ID;
    return 16'(16'h0020 + $urandom_range(0, 39));
  endfunction

  // Monitor: pops the scoreboard whenever the DUT signals completion
  bit cnt_pend = 1'b0;
  int cnt_exp = 0;
  always @(negedge clk) begin
    exp_t x;
    if (!nrst) cnt_pend = 1'b0;
    else begin
      if (cnt_pend) begin
        chk("count", 128'(count), 128'(cnt_exp));
        chk("full", 128'(full), 128'(cnt_exp == DEPTH));
        cnt_pend = 1'b0;
      end
      if (wr_done || search_done) begin
        if (exq.size() == 0) chk("unexpected_done", 128'({wr_done, search_done}), 128'(0));
        else begin
          x = exq.pop_front();
          chk("done_cycle", 128'(cyc), 128'(x.cyc));
          if (x.is_search) begin
            chk("search_done", 128'({search_done, wr_done}), 128'(2'b10));
            chk("best_valid", 128'(best_valid), 128'(x.bvalid));
            if (x.bvalid) chk("best_idx", 128'(best_idx), 128'(x.bidx));
          end else begin
            chk("wr_flags", 128'({wr_done, search_done, wr_hit, wr_drop, wr_evict}),
                128'({1'b1, 1'b0, x.hit, x.drop, x.evict}));
            cnt_pend = 1'b1;
            cnt_exp  = x.cnt;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int r;
    model_reset();
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk("reset_outputs", 128'({busy, wr_done, wr_hit, wr_drop, wr_evict, search_done, full,
                               best_valid, best_idx, count}), 128'(0));
    check_table("reset_table");

    // Basic allocation, hit update and own-ID drop
    do_write(16'h0001, 16'd1, 16'h0010, 16'd500, 16'h0003, 16'd2);
    do_write(16'h0002, 16'd2, 16'h0020, 16'd600, 16'h0003, 16'd2);
    rd_idx = IDXW'(1); #1;
    chk("rd_id_idx1", 128'(rd_id), 128'(16'h0002));
    @(negedge clk);
    do_write(16'h0001, 16'd1, 16'h0050, 16'd450, 16'h0003, 16'd2);
    rd_idx = '0; #1;
    chk("rd_q_idx0", 128'(rd_qvalue), 128'(16'h0050));
    @(negedge clk);
    do_write(MY_ID, 16'd0, 16'h0099, 16'd999, 16'h0000, 16'd0);
    check_table("basic_table");

    // Fill the table, then miss on a full table
    do_clear();
    for (int i = 0; i < DEPTH; i++)
      do_write(16'(16'h0100 + i), 16'($urandom), 16'($urandom), 16'(100 + i), 16'($urandom), 16'($urandom));
    do_write(16'h0777, 16'd7, 16'h0077, 16'd50, 16'h0007, 16'd7);
`ifdef NT_REPLACE_EN
    rd_idx = '0; #1;
    chk("evict_idx0_id", 128'(rd_id), 128'(16'h0777));
    @(negedge clk);
`endif
    check_table("full_table");

    // Best-Q scan with a tie
    do_clear();
    do_write(16'h0011, 16'd1, 16'd5, 16'd10, 16'd0, 16'd0);
    do_write(16'h0012, 16'd1, 16'd9, 16'd10, 16'd0, 16'd0);
    do_write(16'h0013, 16'd1, 16'd9, 16'd10, 16'd0, 16'd0);
    do_write(16'h0014, 16'd1, 16'd3, 16'd10, 16'd0, 16'd0);
    do_search();
    chk("tie_best", 128'({best_valid, best_idx}), 128'({1'b1, IDXW'(1)}));
    do_clear();
    do_search();

    // Randomized traffic
    do_clear();
    repeat (150) begin
      r = int'($urandom_range(0, 99));
      if (r < 80)
        do_write(rand_id(), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      else if (r < 96) do_search();
      else do_clear();
    end
    check_table("random_table");

    // Heartbeat during LOOKUP: write completes, pending clear wins over a new wr_en
    issue_write(16'h0555, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5);
    hb_reset = 1'b1;
    @(negedge clk);
    hb_reset = 1'b0;
    @(negedge clk);
    wr_id = 16'h0999;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    chk("pending_clear_busy", 128'(busy), 128'(1));
    model_clear();
    @(negedge clk);
    chk("pending_clear_count", 128'({full, count}), 128'(0));
    check_table("pending_clear_table");

    // Asynchronous reset in the middle of a write
    do_write(16'h0101, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1);
    wr_id = 16'h0202;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    nrst  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("abort_outputs", 128'({busy, wr_done, search_done, full, best_valid, count}), 128'(0));
    check_table("abort_table");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 128'(exq.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
